// File: rtl/ifmap_stream_feeder.sv
// Streams one row of words from a synchronous-read scratch memory into the IFMap circular
// buffer as {tag, data}, with a one-entry skid register absorbing buffer backpressure.
module ifmap_stream_feeder #(
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned LEN_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  row_len,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  buf_ready,
  output logic                  buf_wen,
  output logic [DATA_WIDTH+1:0] buf_din,
  output logic                  ready,
  output logic                  done
);

  typedef enum logic [1:0] {StIdle, StStream, StFinish} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issue_cnt_q;
  logic [LEN_WIDTH-1:0]  wr_cnt_q;
  logic                  rd_pend_q;
  logic                  skid_vld_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [DATA_WIDTH+1:0] din_q;
  logic                  done_q;

  logic                  in_stream;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [1:0]            tag;
  logic                  last_wr;

  always_comb begin
    in_stream = (state_q == StStream);
    // A new read may only be issued if its return can never collide with a held skid word.
    mem_rd    = in_stream && (issue_cnt_q < len_q) && !skid_vld_q && (!rd_pend_q || buf_ready);
    mem_addr  = base_q + ADDR_WIDTH'(issue_cnt_q);
    buf_wen   = in_stream && buf_ready && (skid_vld_q || rd_pend_q);
    wr_data   = skid_vld_q ? skid_q : mem_data;
    tag       = {wr_cnt_q == '0, wr_cnt_q == len_q - LEN_WIDTH'(1)};
    buf_din   = buf_wen ? {tag, wr_data} : din_q;
    last_wr   = buf_wen && tag[0];
    ready     = (state_q == StIdle);
    done      = done_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      wr_cnt_q    <= '0;
      rd_pend_q   <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_q      <= '0;
      din_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      din_q     <= buf_din;
      done_q    <= 1'b0;
      rd_pend_q <= mem_rd;
      if (mem_rd) issue_cnt_q <= issue_cnt_q + LEN_WIDTH'(1);
      if (buf_wen) wr_cnt_q <= wr_cnt_q + LEN_WIDTH'(1);

      // Skid word drains first; a word returning alongside it takes its place.
      if (skid_vld_q) begin
        if (buf_ready) begin
          if (rd_pend_q) skid_q <= mem_data;
          else skid_vld_q <= 1'b0;
        end
      end else if (rd_pend_q && !buf_ready) begin
        skid_q     <= mem_data;
        skid_vld_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (Start) begin
            if (row_len != '0) begin
              base_q      <= base_addr;
              len_q       <= row_len;
              issue_cnt_q <= '0;
              wr_cnt_q    <= '0;
              state_q     <= StStream;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StStream: begin
          if (last_wr) begin
            state_q <= StFinish;
            done_q  <= 1'b1;
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_stream_feeder.sv
// Bench for ifmap_stream_feeder: directed rows plus randomized rows, each checked against a
// queue of expected {tag, data} words built from the memory image.
module tb_ifmap_stream_feeder;

  localparam int DW = 20;
  localparam int AW = 5;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          Start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] row_len;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          buf_ready;
  logic          buf_wen;
  logic [DW+1:0] buf_din;
  logic          ready;
  logic          done;

  logic [DW-1:0] mem [32];
  logic [DW+1:0] last_din;
  int total  = 0;
  int passed = 0;

  ifmap_stream_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .Start     (Start),
    .base_addr (base_addr),
    .row_len   (row_len),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .buf_ready (buf_ready),
    .buf_wen   (buf_wen),
    .buf_din   (buf_din),
    .ready     (ready),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read scratch memory.
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_buf_wen", buf_wen, 0);
    chk("rst_buf_din", buf_din, 0);
    chk("rst_mem_addr", mem_addr, 0);
  endtask

  // mode: 0 = buffer always ready, 1 = random backpressure, 2 = 3-cycle stall after 2nd write.
  // abort_at > 0: assert reset in the cycle of that write and check the row is abandoned.
  task automatic run_row(input int base, input int len, input int mode, input int abort_at);
    logic [DW+1:0] q[$];
    logic [DW+1:0] exp_w;
    int rd_i = 0, nwr = 0, last_wr_c = -1, first_rd_c = -1, first_wr_c = -1, drop = 0;
    bit fin = 0, aborted = 0;
    for (int i = 0; i < len; i++) q.push_back({i == 0, i == len - 1, mem[(base + i) % 32]});
    for (int c = 0; c < len * 6 + 20 && !fin; c++) begin
      @(posedge clk);
      #1;
      Start     = (c == 0) || (len > 0 && $urandom_range(0, 3) == 0);
      base_addr = (c == 0) ? AW'(base) : AW'($urandom);
      row_len   = (c == 0) ? LW'(len) : LW'($urandom);
      case (mode)
        0: buf_ready = 1'b1;
        1: buf_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (nwr >= 2 && drop < 3) begin
            buf_ready = 1'b0;
            drop++;
          end else begin
            buf_ready = 1'b1;
          end
        end
      endcase
      #1;
      if (c == 0) chk("ready_at_start", ready, 1);
      if (c == 1 && len > 0) chk("busy_during_row", ready, 0);
      if (mem_rd) begin
        chk("read_within_row", rd_i < len, 1);
        chk("mem_addr", mem_addr, (base + rd_i) % 32);
        if (first_rd_c < 0) first_rd_c = c;
        rd_i++;
      end
      if (buf_wen) begin
        chk("wen_only_when_ready", buf_ready, 1);
        chk("no_extra_write", q.size() > 0, 1);
        if (q.size() > 0) begin
          exp_w = q.pop_front();
          chk("buf_din", buf_din, exp_w);
          last_din = exp_w;
        end
        nwr++;
        last_wr_c = c;
        if (first_wr_c < 0) first_wr_c = c;
      end else begin
        chk("buf_din_hold", buf_din, last_din);
      end
      if (abort_at > 0 && buf_wen && nwr == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        Start = 1'b0;
        #1;
        chk_reset_outputs();
        last_din = '0;
        for (int k = 0; k < 4; k++) begin
          @(posedge clk);
          #2;
          chk("abort_no_done", done, 0);
          chk("abort_no_write", buf_wen, 0);
          chk("abort_no_read", mem_rd, 0);
        end
        fin = 1;
        aborted = 1;
      end else if (done) begin
        if (len == 0) chk("done_len0_cycle", c, 1);
        else chk("done_after_last_write", c, last_wr_c + 1);
        chk("all_words_written", q.size(), 0);
        if (mode == 0 && len > 0) begin
          chk("first_read_cycle", first_rd_c, 1);
          chk("first_write_cycle", first_wr_c, 2);
          chk("done_cycle", c, len + 2);
        end
        fin = 1;
      end
    end
    chk("row_finished", fin, 1);
    if (!aborted) begin
      chk("read_count", rd_i, len);
      chk("write_count", nwr, len);
      @(posedge clk);
      #1;
      Start     = 1'b0;
      buf_ready = 1'b1;
      #1;
      chk("done_single_pulse", done, 0);
      chk("idle_ready", ready, 1);
    end
  endtask

  initial begin
    int s1[10] = '{0, 0, -1, 2, -1, -2, 2, 0, 1, 1};
    rst       = 1'b1;
    Start     = 1'b0;
    buf_ready = 1'b1;
    base_addr = '0;
    row_len   = '0;
    for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs();
    rst      = 1'b0;
    last_din = '0;

    for (int i = 0; i < 10; i++) mem[i] = DW'(s1[i]);
    run_row(0, 10, 0, 0);
    mem[7] = DW'(5);
    run_row(7, 1, 0, 0);
    run_row(3, 0, 0, 0);
    run_row(12, 6, 2, 0);
    run_row(30, 4, 0, 0);
    run_row(5, 8, 0, 3);
    run_row(5, 8, 0, 0);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 32; i++) if ($urandom_range(0, 3) == 0) mem[i] = DW'($urandom);
      run_row($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
